// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation timer (Rega Automatica) counter stages.
// The state type, the BCD limit and the default clock rate are kept here so
// that the seconds and minutes stages agree on them.
package rega_pkg;

  // Run-control states. The encoding is visible on the estado output.
  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam int BCD_MAX = 9;
  localparam int CLK_HZ  = 50000000;

  // Limit a loaded digit to the stage maximum so a bad BCD code cannot
  // leave the counter outside its range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler that turns the system clock into a one-cycle tick every DIV_TICK
// clocks. en advances the count, clr returns it to zero (clr has priority),
// and with en low and clr low the count is held, which implements pause.
// tick is combinational from the held count and is only high while en is high.
// Build option ACELERA_SIM_EN: bypass the division so tick follows en every clock.
module divisor_tick
  import rega_pkg::*;
#(
  parameter int DIV_TICK = CLK_HZ
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

`ifdef ACELERA_SIM_EN
  logic unused_ports;

  assign unused_ports = ^{clock, reset_n, clr};
  assign tick = en;
`else
  localparam int W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam logic [W-1:0] LAST = W'(DIV_TICK - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..DIV_TICK-1 while enabled, wrap on the tick, hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/unidades_segundos_ctrl.sv
// Units-of-seconds countdown stage of the irrigation timer.
// A prescaler (divisor_tick) produces a 1 s tick while counting; each tick
// decrements the BCD digit, wraps 0 -> UNIDADE_MAX with a one-clock borrow
// pulse to the tens stage, or finishes the irrigation when both digits are 0.
// Build option ACELERA_SIM_EN: tick on every clock in CONTANDO (fast sim/demo).
//
// Control inputs are level/strobe style, sampled on every rising clock edge:
// carregar is a one-cycle load strobe that wins over any coincident tick,
// iniciar and pausar are levels, and pausar wins over a coincident tick.
// Pulso_DS and tick_1s are single-cycle pulses with no acknowledge.
module unidades_segundos_ctrl
  import rega_pkg::*;
#(
  parameter int DIV_TICK    = CLK_HZ,
  parameter int UNIDADE_MAX = BCD_MAX
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       carregar,
  input  logic [3:0] valor_carga,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       dezenas_zero,
  output logic [3:0] QUSegundos,
  output logic       Pulso_DS,
  output logic       tick_1s,
  output logic       fim,
  output logic [1:0] estado
);

  localparam logic [3:0] DIGIT_MAX = 4'(UNIDADE_MAX);

  estado_t    state, state_next;
  logic [3:0] digit, digit_next;
  logic       pulso, pulso_next;
  logic       run_en;
  logic       div_clr;
  logic       tick;

  // Prescaler runs only while counting and not being paused this cycle;
  // it is zeroed on load and whenever the stage is stopped or finished.
  assign run_en  = (state == CONTANDO) && !pausar;
  assign div_clr = carregar || (state == PARADO) || (state == FIM);

  divisor_tick #(
    .DIV_TICK(DIV_TICK)
  ) u_divisor_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (run_en),
    .clr    (div_clr),
    .tick   (tick)
  );

  // Next-state, next-digit and borrow decision for this cycle.
  always_comb begin
    state_next = state;
    digit_next = digit;
    pulso_next = 1'b0;

    case (state)
      PARADO: begin
        if (iniciar) state_next = CONTANDO;
      end
      CONTANDO: begin
        if (pausar) begin
          state_next = PAUSADO;
        end else if (tick && !carregar && (digit == 4'd0) && dezenas_zero) begin
          state_next = FIM;
        end
      end
      PAUSADO: begin
        if (iniciar && !pausar) state_next = CONTANDO;
      end
      FIM: begin
        if (carregar) state_next = PARADO;
      end
      default: state_next = PARADO;
    endcase

    if (carregar) begin
      digit_next = bcd_clamp(valor_carga, DIGIT_MAX);
    end else if (tick) begin
      if (digit != 4'd0) begin
        digit_next = digit - 4'd1;
      end else if (!dezenas_zero) begin
        digit_next = DIGIT_MAX;
        pulso_next = 1'b1;
      end
    end
  end

  // State, digit and borrow registers; reset clears them immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= PARADO;
      digit <= 4'd0;
      pulso <= 1'b0;
    end else begin
      state <= state_next;
      digit <= digit_next;
      pulso <= pulso_next;
    end
  end

  assign QUSegundos = digit;
  assign Pulso_DS   = pulso;
  assign tick_1s    = tick;
  assign fim        = (state == FIM);
  assign estado     = state;

endmodule
